// File: rtl/mips_main_control.sv
// Multicycle main control FSM for the MIPS datapath: sequences fetch, decode and
// per-instruction execute/memory/write-back states with a configurable memory wait.
module mips_main_control #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic       brk,
    input  logic       zero,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_src,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       halted,
    output logic       illegal,
    output logic [3:0] state_dbg
);

    localparam int unsigned CNT_W = 3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LUI   = 6'h0F;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_R_EXEC    = 4'd2,
        S_R_WB      = 4'd3,
        S_ADDR      = 4'd4,
        S_LW_READ   = 4'd5,
        S_LW_WB     = 4'd6,
        S_SW_WRITE  = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_LUI_WB    = 4'd12,
        S_HALT      = 4'd13,
        S_ILLEGAL   = 4'd14
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               wait_done;

    // The branch decision itself is taken in the datapath from zero/branch_ne.
    logic unused_zero;
    assign unused_zero = zero;

    assign wait_done = (wait_cnt_q == CNT_W'(MEM_WAIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Outputs are forced low while reset is asserted so an abandoned instruction writes nothing.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = '0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_src        = 2'b00;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 2'b00;
        halted        = 1'b0;
        illegal       = 1'b0;
        state_dbg     = 4'd0;

        if (reset_n) begin
            state_dbg = 4'(state_q);
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (wait_done) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_RTYPE:      state_d = brk ? S_HALT : S_R_EXEC;
                        OP_LW, OP_SW:  state_d = S_ADDR;
                        OP_BEQ, OP_BNE: state_d = S_BRANCH;
                        OP_J:          state_d = S_JUMP;
                        OP_ADDI:       state_d = S_ADDI_EXEC;
                        OP_LUI:        state_d = S_LUI_WB;
                        default:       state_d = S_ILLEGAL;
                    endcase
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_R_WB;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_LW) ? S_LW_READ : S_SW_WRITE;
                end
                S_LW_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                    if (wait_done) begin
                        state_d = S_LW_WB;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                S_LW_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b01;
                    state_d    = S_FETCH;
                end
                S_SW_WRITE: begin
                    iord = 1'b1;
                    if (wait_done) begin
                        mem_write = 1'b1;
                        state_d   = S_FETCH;
                    end else begin
                        wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    end
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_src        = 2'b01;
                    branch_ne     = (opcode == OP_BNE);
                    state_d       = S_FETCH;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                    state_d  = S_FETCH;
                end
                S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = S_ADDI_WB;
                end
                S_ADDI_WB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_LUI_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'b10;
                    state_d    = S_FETCH;
                end
                S_HALT:    halted  = 1'b1;
                S_ILLEGAL: illegal = 1'b1;
                default:   state_d = S_FETCH;
            endcase
        end
    end

endmodule
